// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory pipeline stage.
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int RN_W   = 5;
  localparam int LAT_W  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_out;
    logic              m2reg;
    logic              wreg;
    logic [RN_W-1:0]   rn;
  } wb_reg_t;

endpackage

// File: rtl/mem_stage_if.sv
// EXE/MEM inputs, stall feedback and MEM/WB outputs of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [WORD_W-1:0] mem_Alu_Result;
  logic [WORD_W-1:0] mem_rb;
  logic              mem_wmem;
  logic              mem_m2reg;
  logic              mem_wreg;
  logic [RN_W-1:0]   mem_rn;

  logic              mem_stall;

  logic [WORD_W-1:0] wb_Alu_Result;
  logic [WORD_W-1:0] wb_mem_out;
  logic              wb_m2reg;
  logic              wb_wreg;
  logic [RN_W-1:0]   wb_rn;

  // Upstream pipeline side: drives EXE/MEM, observes stall and MEM/WB.
  modport master (
    output mem_Alu_Result, mem_rb, mem_wmem, mem_m2reg, mem_wreg, mem_rn,
    input  mem_stall,
    input  wb_Alu_Result, wb_mem_out, wb_m2reg, wb_wreg, wb_rn
  );

  // Memory stage side.
  modport slave (
    input  mem_Alu_Result, mem_rb, mem_wmem, mem_m2reg, mem_wreg, mem_rn,
    output mem_stall,
    output wb_Alu_Result, wb_mem_out, wb_m2reg, wb_wreg, wb_rn
  );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Data memory: combinational read, synchronous write. Contents are never reset.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port, one word per enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory access with configurable latency, upstream stall
// generation and the MEM/WB pipeline register.
//
// state   | meaning
// IDLE    | no access in flight; non-memory ops pass, LAT=1 accesses complete
// WAIT    | multi-cycle access in flight; cnt counts remaining stall cycles
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int LAT    = 3,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        clrn,
  mem_stage_if.slave  bus
);

  // Stall cycles still to run after leaving IDLE; unused when LAT=1.
  localparam logic [LAT_W-1:0] CNT_INIT = (LAT > 1) ? LAT_W'(LAT - 2) : '0;

  logic [0:0]        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  wb_reg_t           wb_q, wb_d;

  logic              access;
  logic              stall;
  logic              complete;
  logic              ram_we;
  logic [ADDR_W-1:0] idx;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr_bits;

  assign access = bus.mem_wmem | bus.mem_m2reg;
  assign idx    = bus.mem_Alu_Result[ADDR_W+1:2];

  // Byte offset and bits above the memory size do not select a word.
  assign unused_addr_bits = ^{bus.mem_Alu_Result[WORD_W-1:ADDR_W+2],
                              bus.mem_Alu_Result[1:0]};

  // Access FSM: decide stall and the completion edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (LAT == 1) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset gates both the stall and the write so an interrupted access is dropped.
  assign ram_we        = complete & bus.mem_wmem & clrn;
  assign bus.mem_stall = stall & clrn;

  data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (idx),
    .wdata_i (bus.mem_rb),
    .rdata_o (rdata)
  );

  // MEM/WB next value: a zero bubble while stalling, otherwise the instruction.
  always_comb begin
    wb_d = '0;
    if (!stall) begin
      wb_d.alu_result = bus.mem_Alu_Result;
      wb_d.mem_out    = rdata;
      wb_d.m2reg      = bus.mem_m2reg;
      wb_d.wreg       = bus.mem_wreg;
      wb_d.rn         = bus.mem_rn;
    end
  end

  // State, counter and MEM/WB register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.wb_Alu_Result = wb_q.alu_result;
  assign bus.wb_mem_out    = wb_q.mem_out;
  assign bus.wb_m2reg      = wb_q.m2reg;
  assign bus.wb_wreg       = wb_q.wreg;
  assign bus.wb_rn         = wb_q.rn;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a LAT=3 instance and a LAT=1 instance.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic clrn;

  always #5 clk = ~clk;

  mem_stage_if if3();
  mem_stage_if if1();

  mem_stage #(.LAT(3), .DEPTH(64), .ADDR_W(6)) dut3 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if3.slave)
  );

  mem_stage #(.LAT(1), .DEPTH(64), .ADDR_W(6)) dut1 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if1.slave)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem_out;
    logic        m2reg;
    logic        wreg;
    logic        chk_mem;
    logic [4:0]  rn;
  } exp_t;

  exp_t        sb3[$];
  exp_t        sb1[$];
  logic [31:0] ram3 [64];
  logic [31:0] ram1 [64];
  bit          known3 [64];
  bit          known1 [64];

  int checks   = 0;
  int failures = 0;

  task automatic nop3();
    if3.mem_wmem  = 1'b0;
    if3.mem_m2reg = 1'b0;
    if3.mem_wreg  = 1'b0;
  endtask

  // Present one instruction to the LAT=3 instance (at posedge+1), check the
  // stall/bubble sequence and the retired MEM/WB contents.
  task automatic issue3(input string name, input logic [31:0] addr, input logic [31:0] rb,
                        input logic wmem, input logic m2reg, input logic wreg,
                        input logic [4:0] rn, output int stalls);
    exp_t       e;
    logic [5:0] idx;
    int         exp_stalls;
    bit         done;
    idx = addr[7:2];
    if3.mem_Alu_Result = addr;
    if3.mem_rb         = rb;
    if3.mem_wmem       = wmem;
    if3.mem_m2reg      = m2reg;
    if3.mem_wreg       = wreg;
    if3.mem_rn         = rn;
    e.alu     = addr;
    e.mem_out = ram3[idx];
    e.chk_mem = m2reg && known3[idx];
    e.m2reg   = m2reg;
    e.wreg    = wreg;
    e.rn      = rn;
    sb3.push_back(e);
    if (wmem) begin
      ram3[idx]   = rb;
      known3[idx] = 1'b1;
    end
    exp_stalls = (wmem || m2reg) ? 2 : 0;
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (if3.mem_stall) begin
        stalls++;
        @(posedge clk);
        #1;
        checks++;
        if (if3.wb_wreg !== 1'b0 || if3.wb_m2reg !== 1'b0) begin
          failures++;
          $display("FAIL %s bubble: wb_wreg=%b wb_m2reg=%b, required 0 0", name,
                   if3.wb_wreg, if3.wb_m2reg);
        end
        if (stalls > 20) begin
          failures++;
          $display("FAIL %s timeout: stall still high after %0d cycles", name, stalls);
          void'(sb3.pop_front());
          done = 1'b1;
        end
      end else begin
        @(posedge clk);
        #1;
        e = sb3.pop_front();
        checks++;
        if (if3.wb_Alu_Result !== e.alu || if3.wb_wreg !== e.wreg ||
            if3.wb_m2reg !== e.m2reg || if3.wb_rn !== e.rn) begin
          failures++;
          $display("FAIL %s wb: alu=%h wreg=%b m2reg=%b rn=%0d, required alu=%h wreg=%b m2reg=%b rn=%0d",
                   name, if3.wb_Alu_Result, if3.wb_wreg, if3.wb_m2reg, if3.wb_rn,
                   e.alu, e.wreg, e.m2reg, e.rn);
        end
        if (e.chk_mem) begin
          checks++;
          if (if3.wb_mem_out !== e.mem_out) begin
            failures++;
            $display("FAIL %s load data: got %h, required %h", name, if3.wb_mem_out, e.mem_out);
          end
        end
        done = 1'b1;
      end
    end
    checks++;
    if (stalls != exp_stalls) begin
      failures++;
      $display("FAIL %s stall count: got %0d, required %0d", name, stalls, exp_stalls);
    end
    nop3();
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) begin
      if3.mem_Alu_Result = $urandom;
      if3.mem_rb         = $urandom;
      if3.mem_wmem       = 1'($urandom);
      if3.mem_m2reg      = 1'($urandom);
      if3.mem_wreg       = 1'($urandom);
      if3.mem_rn         = 5'($urandom);
      if1.mem_Alu_Result = $urandom;
      if1.mem_rb         = $urandom;
      if1.mem_wmem       = 1'($urandom);
      if1.mem_m2reg      = 1'($urandom);
      if1.mem_wreg       = 1'($urandom);
      if1.mem_rn         = 5'($urandom);
      @(negedge clk);
      checks++;
      if ({if3.wb_Alu_Result, if3.wb_mem_out, if3.wb_m2reg, if3.wb_wreg, if3.wb_rn,
           if3.mem_stall} !== '0) begin
        failures++;
        $display("FAIL reset lat3: alu=%h mem=%h m2reg=%b wreg=%b rn=%0d stall=%b, required all 0",
                 if3.wb_Alu_Result, if3.wb_mem_out, if3.wb_m2reg, if3.wb_wreg, if3.wb_rn,
                 if3.mem_stall);
      end
      checks++;
      if ({if1.wb_Alu_Result, if1.wb_mem_out, if1.wb_m2reg, if1.wb_wreg, if1.wb_rn,
           if1.mem_stall} !== '0) begin
        failures++;
        $display("FAIL reset lat1: alu=%h mem=%h m2reg=%b wreg=%b rn=%0d stall=%b, required all 0",
                 if1.wb_Alu_Result, if1.wb_mem_out, if1.wb_m2reg, if1.wb_wreg, if1.wb_rn,
                 if1.mem_stall);
      end
    end
    if3.mem_Alu_Result = 32'h1234; if3.mem_wmem = 1'b0; if3.mem_m2reg = 1'b0;
    if3.mem_wreg = 1'b1; if3.mem_rn = 5'd5;
    if1.mem_Alu_Result = 32'h1234; if1.mem_wmem = 1'b0; if1.mem_m2reg = 1'b0;
    if1.mem_wreg = 1'b1; if1.mem_rn = 5'd5;
    clrn = 1'b1;
    #1;
    checks++;
    if (if3.mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset release stall: got %b, required 0", if3.mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if3.wb_Alu_Result !== 32'h1234 || if3.wb_wreg !== 1'b1 || if3.wb_rn !== 5'd5) begin
      failures++;
      $display("FAIL first op lat3: alu=%h wreg=%b rn=%0d, required 1234 1 5",
               if3.wb_Alu_Result, if3.wb_wreg, if3.wb_rn);
    end
    checks++;
    if (if1.wb_Alu_Result !== 32'h1234 || if1.wb_wreg !== 1'b1 || if1.wb_rn !== 5'd5) begin
      failures++;
      $display("FAIL first op lat1: alu=%h wreg=%b rn=%0d, required 1234 1 5",
               if1.wb_Alu_Result, if1.wb_wreg, if1.wb_rn);
    end
    nop3();
    if1.mem_wreg = 1'b0;
  endtask

  task automatic test_store_load();
    int s;
    issue3("store_10", 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0, s);
    issue3("load_10", 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, s);
  endtask

  task automatic test_wrap();
    int s;
    issue3("store_113", 32'h113, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 5'd0, s);
    issue3("load_10_wrap", 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12, s);
  endtask

  // LAT=1: alternating store/load at full rate, one result per edge.
  task automatic test_lat1();
    exp_t       e;
    logic [31:0] addr;
    logic [5:0] idx;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h100 + 32'((i / 2) * 12) + 32'(i % 2);
      idx  = addr[7:2];
      if1.mem_Alu_Result = addr;
      if1.mem_rb         = 32'h1000_0000 + 32'(i * 32'h111);
      if1.mem_wmem       = (i % 2 == 0);
      if1.mem_m2reg      = (i % 2 == 1);
      if1.mem_wreg       = (i % 2 == 1);
      if1.mem_rn         = 5'(i + 16);
      e.alu     = addr;
      e.mem_out = ram1[idx];
      e.chk_mem = if1.mem_m2reg && known1[idx];
      e.m2reg   = if1.mem_m2reg;
      e.wreg    = if1.mem_wreg;
      e.rn      = if1.mem_rn;
      sb1.push_back(e);
      if (if1.mem_wmem) begin
        ram1[idx]   = if1.mem_rb;
        known1[idx] = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (if1.mem_stall !== 1'b0) begin
        failures++;
        $display("FAIL lat1 stall op %0d: got %b, required 0", i, if1.mem_stall);
      end
      @(posedge clk);
      #1;
      e = sb1.pop_front();
      checks++;
      if (if1.wb_Alu_Result !== e.alu || if1.wb_wreg !== e.wreg ||
          if1.wb_m2reg !== e.m2reg || if1.wb_rn !== e.rn) begin
        failures++;
        $display("FAIL lat1 wb op %0d: alu=%h wreg=%b m2reg=%b rn=%0d, required alu=%h wreg=%b m2reg=%b rn=%0d",
                 i, if1.wb_Alu_Result, if1.wb_wreg, if1.wb_m2reg, if1.wb_rn,
                 e.alu, e.wreg, e.m2reg, e.rn);
      end
      if (e.chk_mem) begin
        checks++;
        if (if1.wb_mem_out !== e.mem_out) begin
          failures++;
          $display("FAIL lat1 load op %0d: got %h, required %h", i, if1.wb_mem_out, e.mem_out);
        end
      end
    end
    if1.mem_wmem  = 1'b0;
    if1.mem_m2reg = 1'b0;
    if1.mem_wreg  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s;
    issue3("store_20_init", 32'h20, 32'h11111111, 1'b1, 1'b0, 1'b0, 5'd0, s);
    if3.mem_Alu_Result = 32'h20;
    if3.mem_rb         = 32'h55;
    if3.mem_wmem       = 1'b1;
    if3.mem_m2reg      = 1'b0;
    if3.mem_wreg       = 1'b0;
    if3.mem_rn         = 5'd0;
    @(negedge clk);
    checks++;
    if (if3.mem_stall !== 1'b1) begin
      failures++;
      $display("FAIL midreset stall1: got %b, required 1", if3.mem_stall);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (if3.mem_stall !== 1'b1) begin
      failures++;
      $display("FAIL midreset stall2: got %b, required 1", if3.mem_stall);
    end
    #1;
    clrn = 1'b0;
    #1;
    checks++;
    if ({if3.mem_stall, if3.wb_wreg, if3.wb_m2reg, if3.wb_Alu_Result} !== '0) begin
      failures++;
      $display("FAIL midreset outputs: stall=%b wreg=%b m2reg=%b alu=%h, required all 0",
               if3.mem_stall, if3.wb_wreg, if3.wb_m2reg, if3.wb_Alu_Result);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    if3.mem_Alu_Result = 32'hCAFE;
    if3.mem_wmem       = 1'b0;
    if3.mem_wreg       = 1'b1;
    if3.mem_rn         = 5'd3;
    clrn = 1'b1;
    #1;
    checks++;
    if (if3.mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL midreset release stall: got %b, required 0", if3.mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if3.wb_Alu_Result !== 32'hCAFE || if3.wb_wreg !== 1'b1 || if3.wb_rn !== 5'd3) begin
      failures++;
      $display("FAIL midreset passthru: alu=%h wreg=%b rn=%0d, required cafe 1 3",
               if3.wb_Alu_Result, if3.wb_wreg, if3.wb_rn);
    end
    nop3();
    issue3("load_20_after_reset", 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7, s);
  endtask

  task automatic test_back_to_back();
    int s0;
    int s1;
    issue3("b2b_setup0", 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0, 5'd0, s0);
    issue3("b2b_setup4", 32'h4, 32'h02020202, 1'b1, 1'b0, 1'b0, 5'd0, s0);
    issue3("b2b_load0", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1, s0);
    issue3("b2b_load4", 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, s1);
    checks++;
    if (s0 + s1 != 4) begin
      failures++;
      $display("FAIL b2b total stalls: got %0d, required 4", s0 + s1);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram3[i]   = '0;
      ram1[i]   = '0;
      known3[i] = 1'b0;
      known1[i] = 1'b0;
    end
    if3.mem_rb = '0;
    if1.mem_rb = '0;
    test_reset();
    test_store_load();
    test_wrap();
    test_lat1();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined CPU. It consumes the EXE/MEM pipeline-register outputs, performs the data-memory access, and drives the MEM/WB pipeline register.
- The data memory has a configurable access latency. For multi-cycle accesses, the block raises mem_stall to freeze PC, IF/ID, ID/EXE and EXE/MEM, and inserts bubbles into WB until the access completes.
- It is the receiving end of the EXE/MEM register interface and the driving end of MEM/WB.

Parameters:
- LAT, 3, data-memory access latency in cycles per load/store; legal range 1..15. LAT=1 means no stalls.
- DEPTH, 64, data-memory size in 32-bit words; must be a power of 2.
- ADDR_W, 6, word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- mem_Alu_Result  in  32  byte address for loads/stores; pass-through result otherwise.
- mem_rb  in  32  store data.
- mem_wmem  in  1  store request.
- mem_m2reg  in  1  load request (writeback selects memory data).
- mem_wreg  in  1  instruction writes the register file.
- mem_rn  in  5  destination register number.
- mem_stall  out  1  combinational; holds all upstream stages while high.
- wb_Alu_Result  out  32  registered ALU result.
- wb_mem_out  out  32  registered load data.
- wb_m2reg  out  1  registered m2reg.
- wb_wreg  out  1  registered wreg.
- wb_rn  out  5  registered destination register.

Behaviour:
- Reset: clk and clrn form one clock domain. Reset is asynchronous and active-low. While clrn=0:
  - all wb_* outputs are 0;
  - FSM is IDLE and the latency counter is 0;
  - mem_stall is 0;
  - RAM contents are not reset.
- Access definition: an access is pending when mem_wmem or mem_m2reg is 1. If both are 1, the store takes precedence and the load data is still returned.
- Address: word index = mem_Alu_Result[ADDR_W+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH.
- FSM states:
  - IDLE: if no access is pending, mem_stall=0 and MEM/WB captures the inputs at the edge.
  - IDLE with an access pending and LAT=1: completes in the same cycle, no stall.
  - IDLE with an access pending and LAT>1: mem_stall=1 in the same cycle. At the edge, go to WAIT with cnt=LAT-2 and capture a bubble into MEM/WB.
  - WAIT: if cnt!=0, mem_stall=1, cnt decrements, and a bubble is captured. If cnt==0, mem_stall=0 and the access completes at this edge; go to IDLE.
- Bubble: wb_wreg=0 and wb_m2reg=0. wb_rn, wb_Alu_Result and wb_mem_out are don't-care; they are driven to 0.
- Completion edge:
  - a store writes RAM[idx] <= mem_rb exactly once;
  - wb_mem_out <= RAM[idx] (pre-write value if the same instruction stores);
  - the remaining wb_* outputs capture the corresponding mem_* inputs.
- Total occupancy: each access occupies exactly LAT cycles in MEM and causes exactly LAT-1 stall cycles. A non-memory instruction occupies 1 cycle.
- Back-to-back accesses: the next access starts in IDLE on the cycle after completion and is not merged. A load following a store to the same address returns the stored value.
- Input stability: the EXE/MEM register is held by mem_stall, so inputs are stable through WAIT. The block samples idx and mem_rb only at the completion edge.
- Reset mid-access: the FSM returns to IDLE, no RAM write occurs, and outputs are 0. The interrupted access is lost; upstream is reset by the same clrn.
- Forwarding: wb_* outputs feed the forwarding unit unchanged. Bubbles carry wb_wreg=0, so nothing is forwarded from a stalled MEM stage.

Decomposition:
- Shared package holds:
  - cpu_pkg constants: word width 32, register-number width 5;
  - FSM state encoding: IDLE=1'b0, WAIT=1'b1;
  - LAT_W=4 counter width.
- One sub-module, data_ram (DEPTH x 32): combinational read, synchronous write with a write-enable. It is instantiated once. The FSM, counter and MEM/WB register stay in mem_stage.

Test Plan:
- Reset: hold clrn=0 with random inputs -> all wb_*=0 and mem_stall=0. Release clrn with mem_wmem=mem_m2reg=0, mem_Alu_Result=0x1234, mem_wreg=1, mem_rn=5 -> next edge gives wb_Alu_Result=0x1234, wb_wreg=1, wb_rn=5, with no stall.
- Store then load, LAT=3:
  - store mem_Alu_Result=0x10, mem_rb=0xDEADBEEF -> mem_stall high for exactly 2 cycles, 2 bubbles (wb_wreg=0), RAM[4]=0xDEADBEEF after the 3rd edge;
  - then load 0x10 with mem_rn=9 -> 2 stall cycles, then wb_mem_out=0xDEADBEEF, wb_m2reg=1, wb_rn=9.
- Wrap/alignment: store 0xA5A5A5A5 to address 0x113 -> RAM index 4. Load from 0x10 returns 0xA5A5A5A5.
- LAT=1 build: alternating loads and stores at full rate -> mem_stall never asserts; each load result appears one edge after presentation.
- Reset mid-access: assert clrn=0 during the 2nd stall cycle of a store of 0x55 to 0x20 -> after release, RAM[8] is unchanged, mem_stall=0 and the FSM is IDLE (the next non-memory instruction passes in 1 cycle).
- Back-to-back loads to 0x0 and 0x4 with LAT=3 -> exactly 4 stall cycles in total, both results in order, and no bubble leaks wb_wreg=1.
